// File: rtl/final_adder_pipe.sv
// Two-stage pipelined carry-propagate adder: row0 + row1 -> 12-bit product.
// Optional macro PROD_CNT_EN adds a saturating delivered-product counter on prod_cnt.
module final_adder_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] row0,
  input  logic [10:0] row1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] product
`ifdef PROD_CNT_EN
  ,
  output logic [15:0] prod_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a raised out_valid holds with stable
  // product until out_ready is seen.

  logic        r_a_vld;
  logic [5:0]  r_a_lo;
  logic        r_a_c;
  logic [4:0]  r_a_hi0;
  logic [4:0]  r_a_hi1;
  logic        r_b_vld;
  logic [11:0] r_b_prod;

  logic        w_adv_a;
  logic        w_adv_b;
  logic        w_accept;
  logic [6:0]  w_lo_sum;
  logic [5:0]  w_hi_sum;

  assign w_adv_b  = !r_b_vld || out_ready;
  assign w_adv_a  = !r_a_vld || w_adv_b;
  assign w_accept = in_valid && w_adv_a;

  assign w_lo_sum = {1'b0, row0[5:0]} + {1'b0, row1[5:0]};
  // Upper half completes in stage B, absorbing the carry out of the low half.
  assign w_hi_sum = {1'b0, r_a_hi0} + {1'b0, r_a_hi1} + {5'b0_0000, r_a_c};

  assign in_ready  = w_adv_a;
  assign out_valid = r_b_vld;
  assign product   = r_b_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_vld <= 1'b0;
      r_a_lo  <= 6'd0;
      r_a_c   <= 1'b0;
      r_a_hi0 <= 5'd0;
      r_a_hi1 <= 5'd0;
    end else if (w_adv_a) begin
      r_a_vld <= in_valid;
      if (w_accept) begin
        r_a_lo  <= w_lo_sum[5:0];
        r_a_c   <= w_lo_sum[6];
        r_a_hi0 <= row0[10:6];
        r_a_hi1 <= row1[10:6];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_vld  <= 1'b0;
      r_b_prod <= 12'h000;
    end else if (w_adv_b) begin
      r_b_vld <= r_a_vld;
      if (r_a_vld) begin
        r_b_prod <= {w_hi_sum, r_a_lo};
      end
    end
  end

`ifdef PROD_CNT_EN
  logic [15:0] r_prod_cnt;
  logic        w_deliver;

  assign w_deliver = r_b_vld && out_ready;
  assign prod_cnt  = r_prod_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_cnt <= 16'h0000;
    end else if (w_deliver && (r_prod_cnt != 16'hFFFF)) begin
      r_prod_cnt <= r_prod_cnt + 16'h0001;
    end
  end
`endif

endmodule
